// File: rtl/umi_arb_pkg.sv
// Shared opcode constants and response-expectation decode for the UMI RAM arbiter.
package umi_arb_pkg;

  localparam int unsigned OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] UMI_REQ_RD     = 5'h01;
  localparam logic [OPCODE_W-1:0] UMI_REQ_WR     = 5'h03;
  localparam logic [OPCODE_W-1:0] UMI_REQ_POSTED = 5'h05;
  localparam logic [OPCODE_W-1:0] UMI_REQ_ATOMIC = 5'h09;

  // True for opcodes whose completion comes back through the response channel
  function automatic logic needs_resp(input logic [OPCODE_W-1:0] opcode);
    return (opcode == UMI_REQ_RD) || (opcode == UMI_REQ_WR) || (opcode == UMI_REQ_ATOMIC);
  endfunction

endpackage

// File: rtl/umi_arb_tag_fifo.sv
// In-order FIFO of host indices awaiting a device response.
// Pointers carry a wrap bit so full and empty are distinguishable.
module umi_arb_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned LW = $clog2(DEPTH);
  localparam int unsigned PW = LW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[LW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[LW-1:0]];
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[LW-1:0] == rd_ptr[LW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/umi_ram_arbiter.sv
// Round-robin arbiter sharing one UMI device among NHOST hosts, with in-order response steering.
// Optional statistics counters are enabled by defining UMI_RAM_ARBITER_STATS_EN.
module umi_ram_arbiter
  import umi_arb_pkg::*;
#(
  parameter int unsigned NHOST = 2,
  parameter int unsigned DW    = 256,
  parameter int unsigned AW    = 64,
  parameter int unsigned CW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NHOST-1:0]    host_req_valid,
  input  logic [NHOST*CW-1:0] host_req_cmd,
  input  logic [NHOST*AW-1:0] host_req_dstaddr,
  input  logic [NHOST*AW-1:0] host_req_srcaddr,
  input  logic [NHOST*DW-1:0] host_req_data,
  output logic [NHOST-1:0]    host_req_ready,
  output logic [NHOST-1:0]    host_resp_valid,
  output logic [NHOST*CW-1:0] host_resp_cmd,
  output logic [NHOST*AW-1:0] host_resp_dstaddr,
  output logic [NHOST*AW-1:0] host_resp_srcaddr,
  output logic [NHOST*DW-1:0] host_resp_data,
  input  logic [NHOST-1:0]    host_resp_ready,
  output logic                udev_req_valid,
  output logic [CW-1:0]       udev_req_cmd,
  output logic [AW-1:0]       udev_req_dstaddr,
  output logic [AW-1:0]       udev_req_srcaddr,
  output logic [DW-1:0]       udev_req_data,
  input  logic                udev_req_ready,
  input  logic                udev_resp_valid,
  input  logic [CW-1:0]       udev_resp_cmd,
  input  logic [AW-1:0]       udev_resp_dstaddr,
  input  logic [AW-1:0]       udev_resp_srcaddr,
  input  logic [DW-1:0]       udev_resp_data,
  output logic                udev_resp_ready,
  output logic                orphan_err
`ifdef UMI_RAM_ARBITER_STATS_EN
  ,
  output logic [NHOST*32-1:0] stat_req_count,
  output logic [31:0]         stat_stall_cycles
`endif
);

  localparam int unsigned GW = (NHOST > 1) ? $clog2(NHOST) : 1;

  typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_t;

  arb_state_t       state_q, state_d;
  logic [GW-1:0]    rr_ptr, rr_ptr_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    g;
  logic             gvalid;
  logic [NHOST-1:0] nr;
  logic [NHOST-1:0] elig;
  logic             fifo_full, fifo_empty;
  logic [GW-1:0]    head;
  logic             req_hs, push, pop;

  // Eligibility: a response-bearing request needs a free tag slot
  always_comb begin
    nr   = '0;
    elig = '0;
    for (int i = 0; i < int'(NHOST); i++) begin
      nr[i]   = needs_resp(host_req_cmd[i*CW +: OPCODE_W]);
      elig[i] = host_req_valid[i] & (~nr[i] | ~fifo_full);
    end
  end

  // Round-robin search from rr_ptr; a stalled grant overrides the search
  always_comb begin
    int idx;
    idx    = 0;
    g      = rr_ptr;
    gvalid = 1'b0;
    for (int k = 0; k < int'(NHOST); k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= int'(NHOST)) idx = idx - int'(NHOST);
      if (!gvalid && elig[GW'(idx)]) begin
        gvalid = 1'b1;
        g      = GW'(idx);
      end
    end
    if (state_q == ARB_LOCKED) begin
      g      = grant_q;
      gvalid = host_req_valid[grant_q];
    end
  end

  assign udev_req_valid   = gvalid & ~rst;
  assign udev_req_cmd     = host_req_cmd[g*CW +: CW];
  assign udev_req_dstaddr = host_req_dstaddr[g*AW +: AW];
  assign udev_req_srcaddr = host_req_srcaddr[g*AW +: AW];
  assign udev_req_data    = host_req_data[g*DW +: DW];

  always_comb begin
    host_req_ready = '0;
    if (gvalid && !rst) host_req_ready[g] = udev_req_ready;
  end

  assign req_hs = udev_req_valid & udev_req_ready;
  assign push   = req_hs & needs_resp(udev_req_cmd[OPCODE_W-1:0]);

  always_comb begin
    state_d  = ARB_OPEN;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr;
    if (udev_req_valid && !udev_req_ready) begin
      state_d = ARB_LOCKED;
      grant_d = g;
    end
    if (req_hs) rr_ptr_d = (g == GW'(NHOST - 1)) ? '0 : g + GW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_OPEN;
      grant_q <= '0;
      rr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_ptr  <= rr_ptr_d;
    end
  end

  umi_arb_tag_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (GW)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (g),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Response steering to the oldest outstanding requester; untagged responses are sunk
  always_comb begin
    host_resp_valid = '0;
    udev_resp_ready = 1'b0;
    pop             = 1'b0;
    if (!rst) begin
      if (!fifo_empty) begin
        host_resp_valid[head] = udev_resp_valid;
        udev_resp_ready       = host_resp_ready[head];
        pop                   = udev_resp_valid & host_resp_ready[head];
      end else begin
        udev_resp_ready = 1'b1;
      end
    end
  end

  assign host_resp_cmd     = {NHOST{udev_resp_cmd}};
  assign host_resp_dstaddr = {NHOST{udev_resp_dstaddr}};
  assign host_resp_srcaddr = {NHOST{udev_resp_srcaddr}};
  assign host_resp_data    = {NHOST{udev_resp_data}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      orphan_err <= 1'b0;
    end else if (udev_resp_valid && fifo_empty) begin
      orphan_err <= 1'b1;
    end
  end

`ifdef UMI_RAM_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_req_count    <= '0;
      stat_stall_cycles <= '0;
    end else begin
      for (int i = 0; i < int'(NHOST); i++) begin
        if (req_hs && (g == GW'(i))) stat_req_count[i*32 +: 32] <= stat_req_count[i*32 +: 32] + 32'd1;
      end
      if (udev_req_valid && !udev_req_ready) stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_umi_ram_arbiter.sv
// Directed bench for umi_ram_arbiter (NHOST=2, DEPTH=4): round-robin, stall lock,
// tag-FIFO full, response back-pressure, orphan response and mid-flight reset.
module tb_umi_ram_arbiter;

  localparam int unsigned NHOST = 2;
  localparam int unsigned DW    = 256;
  localparam int unsigned AW    = 64;
  localparam int unsigned CW    = 32;
  localparam int unsigned DEPTH = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NHOST-1:0]    host_req_valid;
  logic [NHOST*CW-1:0] host_req_cmd;
  logic [NHOST*AW-1:0] host_req_dstaddr;
  logic [NHOST*AW-1:0] host_req_srcaddr;
  logic [NHOST*DW-1:0] host_req_data;
  logic [NHOST-1:0]    host_req_ready;
  logic [NHOST-1:0]    host_resp_valid;
  logic [NHOST*CW-1:0] host_resp_cmd;
  logic [NHOST*AW-1:0] host_resp_dstaddr;
  logic [NHOST*AW-1:0] host_resp_srcaddr;
  logic [NHOST*DW-1:0] host_resp_data;
  logic [NHOST-1:0]    host_resp_ready;
  logic                udev_req_valid;
  logic [CW-1:0]       udev_req_cmd;
  logic [AW-1:0]       udev_req_dstaddr;
  logic [AW-1:0]       udev_req_srcaddr;
  logic [DW-1:0]       udev_req_data;
  logic                udev_req_ready;
  logic                udev_resp_valid;
  logic [CW-1:0]       udev_resp_cmd;
  logic [AW-1:0]       udev_resp_dstaddr;
  logic [AW-1:0]       udev_resp_srcaddr;
  logic [DW-1:0]       udev_resp_data;
  logic                udev_resp_ready;
  logic                orphan_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  umi_ram_arbiter #(
    .NHOST (NHOST), .DW (DW), .AW (AW), .CW (CW), .DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .host_req_valid    (host_req_valid),
    .host_req_cmd      (host_req_cmd),
    .host_req_dstaddr  (host_req_dstaddr),
    .host_req_srcaddr  (host_req_srcaddr),
    .host_req_data     (host_req_data),
    .host_req_ready    (host_req_ready),
    .host_resp_valid   (host_resp_valid),
    .host_resp_cmd     (host_resp_cmd),
    .host_resp_dstaddr (host_resp_dstaddr),
    .host_resp_srcaddr (host_resp_srcaddr),
    .host_resp_data    (host_resp_data),
    .host_resp_ready   (host_resp_ready),
    .udev_req_valid    (udev_req_valid),
    .udev_req_cmd      (udev_req_cmd),
    .udev_req_dstaddr  (udev_req_dstaddr),
    .udev_req_srcaddr  (udev_req_srcaddr),
    .udev_req_data     (udev_req_data),
    .udev_req_ready    (udev_req_ready),
    .udev_resp_valid   (udev_resp_valid),
    .udev_resp_cmd     (udev_resp_cmd),
    .udev_resp_dstaddr (udev_resp_dstaddr),
    .udev_resp_srcaddr (udev_resp_srcaddr),
    .udev_resp_data    (udev_resp_data),
    .udev_resp_ready   (udev_resp_ready),
    .orphan_err        (orphan_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_host(input int i, input logic v, input logic [4:0] op, input logic [63:0] dst);
    host_req_valid[i]            = v;
    host_req_cmd[i*CW +: CW]     = {27'h0, op};
    host_req_dstaddr[i*AW +: AW] = dst;
    host_req_srcaddr[i*AW +: AW] = 64'h1000 + 64'(i);
    host_req_data[i*DW +: DW]    = 256'(dst) ^ 256'hD0;
  endtask

  task automatic set_resp(input logic v, input logic [63:0] d);
    udev_resp_valid   = v;
    udev_resp_cmd     = 32'h0000_000B;
    udev_resp_dstaddr = 64'h2000;
    udev_resp_srcaddr = 64'h3000;
    udev_resp_data    = 256'(d);
  endtask

  initial begin
    rst = 1'b1;
    host_req_valid = '0; host_req_cmd = '0; host_req_dstaddr = '0;
    host_req_srcaddr = '0; host_req_data = '0; host_resp_ready = '0;
    udev_req_ready = 1'b1;
    set_resp(1'b0, 64'h0);
    set_host(0, 1'b1, 5'h03, 64'h100);
    set_host(1, 1'b1, 5'h03, 64'h200);
    #2;
    // Reset state: hosts request but every valid/ready output stays low
    chk("rst_udev_req_valid", 64'(udev_req_valid), 64'd0);
    chk("rst_host_req_ready", 64'(host_req_ready), 64'd0);
    chk("rst_udev_resp_ready", 64'(udev_resp_ready), 64'd0);
    chk("rst_orphan_err", 64'(orphan_err), 64'd0);

    // Round robin: both hosts stream REQ_WR, grants alternate h0,h1,h0,h1
    tick();
    rst = 1'b0;
    host_resp_ready = 2'b11;
    #1;
    chk("rr0_dst", udev_req_dstaddr, 64'h100);
    chk("rr0_ready", 64'(host_req_ready), 64'b01);
    chk("rr0_data", udev_req_data[63:0], 64'h1D0);
    tick(); #1;
    chk("rr1_dst", udev_req_dstaddr, 64'h200);
    chk("rr1_ready", 64'(host_req_ready), 64'b10);
    chk("rr1_src", udev_req_srcaddr, 64'h1001);
    tick(); #1;
    chk("rr2_dst", udev_req_dstaddr, 64'h100);
    chk("rr2_ready", 64'(host_req_ready), 64'b01);
    tick(); #1;
    chk("rr3_dst", udev_req_dstaddr, 64'h200);
    chk("rr3_ready", 64'(host_req_ready), 64'b10);
    // Four tags outstanding: write requests are no longer eligible
    tick(); #1;
    chk("rr_full_valid", 64'(udev_req_valid), 64'd0);
    chk("rr_full_ready", 64'(host_req_ready), 64'd0);

    // Acks return to issuers in order h0,h1,h0,h1
    tick();
    set_host(0, 1'b0, 5'h03, 64'h100);
    set_host(1, 1'b0, 5'h03, 64'h200);
    set_resp(1'b1, 64'hA0);
    #1;
    chk("ack0_valid", 64'(host_resp_valid), 64'b01);
    chk("ack0_data", host_resp_data[DW +: 64], 64'hA0);
    chk("ack0_udev_ready", 64'(udev_resp_ready), 64'd1);
    tick(); set_resp(1'b1, 64'hA1); #1;
    chk("ack1_valid", 64'(host_resp_valid), 64'b10);
    chk("ack1_data", host_resp_data[63:0], 64'hA1);
    tick(); set_resp(1'b1, 64'hA2); #1;
    chk("ack2_valid", 64'(host_resp_valid), 64'b01);
    tick(); set_resp(1'b1, 64'hA3); #1;
    chk("ack3_valid", 64'(host_resp_valid), 64'b10);
    chk("ack3_cmd", 64'(host_resp_cmd[CW +: CW]), 64'h0B);
    tick(); set_resp(1'b0, 64'h0); #1;
    chk("ack_orphan_clear", 64'(orphan_err), 64'd0);
    chk("ack_drained_valid", 64'(host_resp_valid), 64'd0);

    // Device stall: h1 REQ_RD 0x40 locked while h0 competes
    udev_req_ready = 1'b0;
    set_host(1, 1'b1, 5'h01, 64'h40);
    #1;
    chk("stall0_dst", udev_req_dstaddr, 64'h40);
    chk("stall0_ready", 64'(host_req_ready), 64'd0);
    tick();
    set_host(0, 1'b1, 5'h03, 64'h80);
    #1;
    chk("stall1_dst", udev_req_dstaddr, 64'h40);
    for (int c = 2; c < 5; c++) begin
      tick(); #1;
      chk("stall_n_dst", udev_req_dstaddr, 64'h40);
      chk("stall_n_cmd", 64'(udev_req_cmd), 64'h01);
      chk("stall_n_ready", 64'(host_req_ready), 64'd0);
    end
    tick();
    udev_req_ready = 1'b1;
    #1;
    chk("stall_hs_dst", udev_req_dstaddr, 64'h40);
    chk("stall_hs_ready", 64'(host_req_ready), 64'b10);
    tick();
    set_host(1, 1'b0, 5'h01, 64'h40);
    #1;
    chk("after_stall_dst", udev_req_dstaddr, 64'h80);
    chk("after_stall_ready", 64'(host_req_ready), 64'b01);

    // Response back-pressure: pop h1's tag, then hold h0's response 3 cycles
    tick();
    set_host(0, 1'b0, 5'h03, 64'h80);
    set_resp(1'b1, 64'hB0);
    #1;
    chk("bp_h1_valid", 64'(host_resp_valid), 64'b10);
    tick();
    host_resp_ready = 2'b10;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("bp_udev_ready", 64'(udev_resp_ready), 64'd0);
      chk("bp_host_valid", 64'(host_resp_valid), 64'b01);
      tick();
    end
    host_resp_ready = 2'b11;
    #1;
    chk("bp_release_ready", 64'(udev_resp_ready), 64'd1);
    chk("bp_release_valid", 64'(host_resp_valid), 64'b01);

    // Tag FIFO full: four REQ_RD from h0 fill it
    tick();
    set_resp(1'b0, 64'h0);
    for (int c = 0; c < 4; c++) begin
      set_host(0, 1'b1, 5'h01, 64'h300 + 64'(c));
      #1;
      chk("fill_ready", 64'(host_req_ready), 64'b01);
      tick();
    end
    set_host(0, 1'b1, 5'h01, 64'h304);
    set_host(1, 1'b1, 5'h05, 64'h500);
    #1;
    chk("full_posted_ready", 64'(host_req_ready), 64'b10);
    chk("full_posted_cmd", 64'(udev_req_cmd), 64'h05);
    tick();
    set_host(1, 1'b0, 5'h05, 64'h500);
    set_resp(1'b1, 64'hC0);
    #1;
    chk("full_rd_blocked", 64'(host_req_ready), 64'd0);
    chk("full_req_valid", 64'(udev_req_valid), 64'd0);
    chk("full_pop_valid", 64'(host_resp_valid), 64'b01);
    tick();
    set_resp(1'b0, 64'h0);
    #1;
    chk("full_fifth_ready", 64'(host_req_ready), 64'b01);
    chk("full_fifth_dst", udev_req_dstaddr, 64'h304);

    // Drain two tags, then lock h1 with two tags outstanding
    tick();
    set_host(0, 1'b0, 5'h01, 64'h304);
    set_resp(1'b1, 64'hC1);
    #1;
    chk("drain0_valid", 64'(host_resp_valid), 64'b01);
    tick(); #1;
    chk("drain1_valid", 64'(host_resp_valid), 64'b01);
    tick();
    set_resp(1'b0, 64'h0);
    udev_req_ready = 1'b0;
    set_host(0, 1'b1, 5'h03, 64'h700);
    set_host(1, 1'b1, 5'h01, 64'h600);
    #1;
    chk("lock_dst", udev_req_dstaddr, 64'h600);
    tick();
    host_resp_ready = 2'b00;
    set_resp(1'b1, 64'hD0);
    #1;
    chk("locked_dst", udev_req_dstaddr, 64'h600);
    chk("locked_resp_valid", 64'(host_resp_valid), 64'b01);

    // Reset mid-operation: outputs drop while rst is high
    rst = 1'b1;
    #1;
    chk("midrst_req_valid", 64'(udev_req_valid), 64'd0);
    chk("midrst_req_ready", 64'(host_req_ready), 64'd0);
    chk("midrst_resp_valid", 64'(host_resp_valid), 64'd0);
    chk("midrst_resp_ready", 64'(udev_resp_ready), 64'd0);

    // After release: FIFO empty (response is orphaned), next grant goes to h0
    tick();
    rst = 1'b0;
    udev_req_ready = 1'b1;
    host_resp_ready = 2'b11;
    set_host(0, 1'b1, 5'h05, 64'h800);
    #1;
    chk("post_rst_dst", udev_req_dstaddr, 64'h800);
    chk("post_rst_ready", 64'(host_req_ready), 64'b01);
    chk("orphan_udev_ready", 64'(udev_resp_ready), 64'd1);
    chk("orphan_no_host_valid", 64'(host_resp_valid), 64'd0);
    chk("orphan_before_edge", 64'(orphan_err), 64'd0);
    tick();
    set_resp(1'b0, 64'h0);
    set_host(0, 1'b0, 5'h05, 64'h800);
    #1;
    chk("orphan_set", 64'(orphan_err), 64'd1);
    chk("post_rst_rr_dst", udev_req_dstaddr, 64'h600);
    tick();
    set_host(1, 1'b0, 5'h01, 64'h600);
    #1;
    chk("orphan_sticky", 64'(orphan_err), 64'd1);
    chk("idle_req_valid", 64'(udev_req_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
